io_stage: RTL and testbench

IO_STAGE -- requirements
Module: io_stage

---
 rtl/io_stage_pkg.sv | 66 ++++++
 rtl/io_load_aligner.sv | 65 ++++++
 rtl/io_stage.sv | 182 ++++++++++++++++++
 tb/tb_io_stage.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_stage_pkg.sv
// Types shared by the EX -> IO -> WB boundary: the EX result bus, the IO output buses
// and the divide-tracking state encoding.

package ex_stage_params;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } MemSize;

    typedef struct packed {
        logic                    valid;
        logic [DATA_W-1:0]       program_count;
        logic [REG_ADDR_W-1:0]   destination_register;
        logic                    register_write;
        logic [DATA_W-1:0]       alu_result;
        logic                    result_high;
        logic                    result_low;
        logic                    high_low_write;
        logic                    result_is_from_memory;
        logic [1:0]              memory_address_final;
        MemSize                  memory_io_size;
        logic                    memory_io_unsigned;
        logic                    is_load_left;
        logic                    is_load_right;
        logic [DATA_W-1:0]       source_register_data;
        logic                    is_multiply;
        logic                    is_divide;
        logic [2*DATA_W-1:0]     multiply_result;
        logic                    divide_result_valid;
        logic [DATA_W-1:0]       divide_quotient;
        logic [DATA_W-1:0]       divide_remainder;
    } EXToIOData;

endpackage

package io_stage_params;

    import ex_stage_params::*;

    typedef struct packed {
        logic                    valid;
        logic [DATA_W-1:0]       program_count;
        logic [REG_ADDR_W-1:0]   destination_register;
        logic                    register_write;
        logic [DATA_W-1:0]       final_result;
    } IOToWBData;

    typedef struct packed {
        logic                    valid;
        logic                    data_valid;
        logic [REG_ADDR_W-1:0]   write_register;
        logic [DATA_W-1:0]       write_data;
    } IOToIDBackPassData;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_DIV = 2'd1,
        DONE     = 2'd2
    } DivideState;

endpackage

// File: rtl/io_load_aligner.sv
// Load data alignment: picks and extends the addressed byte/halfword from the memory word.
// With IO_UNALIGNED_LOAD_EN defined, left/right partial-word loads merge the memory word
// with the old register value; otherwise they behave as plain word loads.

module io_load_aligner
    import ex_stage_params::*;
(
    input  logic [1:0]        address,
    input  logic [DATA_W-1:0] memory_word,
    input  logic [DATA_W-1:0] register_data,
    input  MemSize            size,
    input  logic              is_unsigned,
    input  logic              is_load_left,
    input  logic              is_load_right,
    output logic [DATA_W-1:0] load_data_c
);

    logic [4:0] byte_shift;
    logic [4:0] half_shift;
    logic [7:0] byte_value;
    logic [15:0] half_value;

    assign byte_shift = {address, 3'b000};
    assign half_shift = {address[1], 4'b0000};
    assign byte_value = memory_word[byte_shift +: 8];
    assign half_value = memory_word[half_shift +: 16];

`ifndef IO_UNALIGNED_LOAD_EN
    logic unused_register_data;
    assign unused_register_data = ^register_data;
`endif

    // Select the aligned, extended load value.
    always_comb begin
        load_data_c = memory_word;
`ifdef IO_UNALIGNED_LOAD_EN
        if (is_load_left) begin
            case (address)
                2'd0:    load_data_c = {memory_word[7:0],  register_data[23:0]};
                2'd1:    load_data_c = {memory_word[15:0], register_data[15:0]};
                2'd2:    load_data_c = {memory_word[23:0], register_data[7:0]};
                default: load_data_c = memory_word;
            endcase
        end else if (is_load_right) begin
            case (address)
                2'd1:    load_data_c = {register_data[31:24], memory_word[31:8]};
                2'd2:    load_data_c = {register_data[31:16], memory_word[31:16]};
                2'd3:    load_data_c = {register_data[31:8],  memory_word[31:24]};
                default: load_data_c = memory_word;
            endcase
        end else begin
`else
        if (is_load_left || is_load_right) begin
            load_data_c = memory_word;
        end else begin
`endif
            case (size)
                MEM_BYTE: load_data_c = {{24{~is_unsigned & byte_value[7]}}, byte_value};
                MEM_HALF: load_data_c = {{16{~is_unsigned & half_value[15]}}, half_value};
                default:  load_data_c = memory_word;
            endcase
        end
    end

endmodule

// File: rtl/io_stage.sv
// IO (memory-access) pipeline stage: holds one EX result, latches the load word and the
// multiply product in its first cycle, stalls on divides until the divider reports done,
// and owns the HI/LO registers, written once when the instruction commits to WB.
// Optional feature macro: IO_UNALIGNED_LOAD_EN (left/right partial-word load merging).

module io_stage
    import ex_stage_params::*;
    import io_stage_params::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_allow_in,
    output logic              io_allow_in,
    input  EXToIOData         ex_to_io_bus,
    input  logic [DATA_W-1:0] data_read_data,
    output IOToWBData         io_to_wb_bus,
    output IOToIDBackPassData io_to_id_back_pass_bus
);

    logic                io_valid;
    logic                first_cycle;
    logic                io_ready_go;
    logic                capture;
    logic                commit;
    EXToIOData           io_data;
    logic [DATA_W-1:0]   mem_word_q;
    logic [2*DATA_W-1:0] product_q;
    logic [DATA_W-1:0]   quotient_q;
    logic [DATA_W-1:0]   remainder_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic [DATA_W-1:0]   mem_word_c;
    logic [2*DATA_W-1:0] product_c;
    logic [DATA_W-1:0]   load_data_c;
    logic [DATA_W-1:0]   final_result_c;
    logic                bp_valid_c;
    DivideState          div_state;
    DivideState          div_next;

    // Live-bus fields that the held copy never consumes.
    logic unused_held_bits;
    assign unused_held_bits = ^{io_data.valid, io_data.multiply_result,
                                io_data.divide_result_valid, io_data.divide_quotient,
                                io_data.divide_remainder};

    assign io_ready_go = (div_state != WAIT_DIV);
    assign io_allow_in = !io_valid || (io_ready_go && wb_allow_in);
    assign capture     = ex_to_io_bus.valid && io_allow_in;
    assign commit      = io_valid && io_ready_go && wb_allow_in;

    // First cycle reads the SRAM/multiplier directly; later cycles use the latched copies.
    assign mem_word_c = first_cycle ? data_read_data : mem_word_q;
    assign product_c  = first_cycle ? ex_to_io_bus.multiply_result : product_q;

    // Stage occupancy and first-cycle flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            io_valid    <= 1'b0;
            first_cycle <= 1'b0;
        end else begin
            if (io_allow_in) begin
                io_valid <= ex_to_io_bus.valid;
            end
            first_cycle <= capture;
        end
    end

    // Datapath holding registers (no reset needed, qualified by io_valid).
    always_ff @(posedge clock) begin
        if (capture) begin
            io_data <= ex_to_io_bus;
        end
        if (first_cycle) begin
            mem_word_q <= data_read_data;
        end
        if (first_cycle && io_data.is_multiply) begin
            product_q <= ex_to_io_bus.multiply_result;
        end
        if ((div_state == WAIT_DIV) && ex_to_io_bus.divide_result_valid) begin
            quotient_q  <= ex_to_io_bus.divide_quotient;
            remainder_q <= ex_to_io_bus.divide_remainder;
        end
    end

    // HI/LO architectural registers, written only at commit.
    always_ff @(posedge clock) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (commit) begin
            if (io_data.is_multiply) begin
                hi_q <= product_c[2*DATA_W-1:DATA_W];
                lo_q <= product_c[DATA_W-1:0];
            end else if (io_data.is_divide) begin
                hi_q <= remainder_q;
                lo_q <= quotient_q;
            end else if (io_data.high_low_write) begin
                if (io_data.result_high) begin
                    hi_q <= io_data.alu_result;
                end
                if (io_data.result_low) begin
                    lo_q <= io_data.alu_result;
                end
            end
        end
    end

    // Divide FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_state <= IDLE;
        end else begin
            div_state <= div_next;
        end
    end

    // Divide FSM next state; a divide can be captured in the same cycle the previous one leaves.
    always_comb begin
        div_next = div_state;
        case (div_state)
            IDLE: begin
                if (capture && ex_to_io_bus.is_divide) begin
                    div_next = WAIT_DIV;
                end
            end
            WAIT_DIV: begin
                if (ex_to_io_bus.divide_result_valid) begin
                    div_next = DONE;
                end
            end
            DONE: begin
                if (commit) begin
                    div_next = (capture && ex_to_io_bus.is_divide) ? WAIT_DIV : IDLE;
                end
            end
            default: div_next = IDLE;
        endcase
    end

    io_load_aligner u_load_aligner (
        .address       (io_data.memory_address_final),
        .memory_word   (mem_word_c),
        .register_data (io_data.source_register_data),
        .size          (io_data.memory_io_size),
        .is_unsigned   (io_data.memory_io_unsigned),
        .is_load_left  (io_data.is_load_left),
        .is_load_right (io_data.is_load_right),
        .load_data_c   (load_data_c)
    );

    // Result selection: HI/LO moves, load data, else the ALU result.
    always_comb begin
        final_result_c = io_data.alu_result;
        if (io_data.register_write && io_data.result_high && !io_data.high_low_write) begin
            final_result_c = hi_q;
        end else if (io_data.register_write && io_data.result_low && !io_data.high_low_write) begin
            final_result_c = lo_q;
        end else if (io_data.result_is_from_memory) begin
            final_result_c = load_data_c;
        end
    end

    // Output bus assembly.
    always_comb begin
        bp_valid_c = io_valid && io_data.register_write;

        io_to_wb_bus                      = '0;
        io_to_wb_bus.valid                = io_valid && io_ready_go;
        io_to_wb_bus.program_count        = io_data.program_count;
        io_to_wb_bus.destination_register = io_data.destination_register;
        io_to_wb_bus.register_write       = io_data.register_write;
        io_to_wb_bus.final_result         = final_result_c;

        io_to_id_back_pass_bus                = '0;
        io_to_id_back_pass_bus.valid          = bp_valid_c;
        io_to_id_back_pass_bus.data_valid     = bp_valid_c && io_ready_go;
        io_to_id_back_pass_bus.write_register = bp_valid_c ? io_data.destination_register
                                                           : REG_ADDR_W'(0);
        io_to_id_back_pass_bus.write_data     = final_result_c;
    end

endmodule

// File: tb/tb_io_stage.sv
// Self-checking bench for io_stage: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a transaction-level model of the stage.

module tb_io_stage;

    import ex_stage_params::*;
    import io_stage_params::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              wb_allow_in;
    logic              io_allow_in;
    EXToIOData         ex_to_io_bus;
    logic [31:0]       data_read_data;
    IOToWBData         io_to_wb_bus;
    IOToIDBackPassData io_to_id_back_pass_bus;

    io_stage dut (
        .clock                  (clock),
        .reset                  (reset),
        .wb_allow_in            (wb_allow_in),
        .io_allow_in            (io_allow_in),
        .ex_to_io_bus           (ex_to_io_bus),
        .data_read_data         (data_read_data),
        .io_to_wb_bus           (io_to_wb_bus),
        .io_to_id_back_pass_bus (io_to_id_back_pass_bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 0;

    // Model of the stage contents: the held instruction and what it has collected so far.
    bit          m_valid    = 0;
    bit          m_first    = 0;
    bit          m_div_wait = 0;
    EXToIOData   m_inst     = '0;
    logic [31:0] m_word     = '0;
    logic [63:0] m_prod     = '0;
    logic [31:0] m_quot     = '0;
    logic [31:0] m_rem      = '0;
    logic [31:0] m_hi       = '0;
    logic [31:0] m_lo       = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input EXToIOData d, input logic [31:0] w);
        int a;
        logic [63:0] m;
        logic [63:0] r;
        logic [31:0] v;
        a = int'(d.memory_address_final);
        m = {32'd0, w};
        r = {32'd0, d.source_register_data};
`ifdef IO_UNALIGNED_LOAD_EN
        if (d.is_load_left)
            return 32'((m << (8 * (3 - a))) | (r & ((64'd1 << (8 * (3 - a))) - 64'd1)));
        if (d.is_load_right)
            return 32'((m >> (8 * a)) | (r & ~(64'hFFFF_FFFF >> (8 * a))));
`else
        if (d.is_load_left || d.is_load_right) return w;
`endif
        if (d.memory_io_size == MEM_BYTE) begin
            v = (w >> (8 * a)) & 32'hFF;
            if (!d.memory_io_unsigned && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (d.memory_io_size == MEM_HALF) begin
            v = (w >> (16 * (a / 2))) & 32'hFFFF;
            if (!d.memory_io_unsigned && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_final(input logic [31:0] w);
        if (m_inst.register_write && m_inst.result_high && !m_inst.high_low_write) return m_hi;
        if (m_inst.register_write && m_inst.result_low && !m_inst.high_low_write) return m_lo;
        if (m_inst.result_is_from_memory) return model_load(m_inst, w);
        return m_inst.alu_result;
    endfunction

    // Compare every DUT output against the model, away from the clock edge.
    task automatic compare_outputs();
        bit rg;
        bit bpv;
        logic [31:0] w;
        if (!armed) return;
        rg  = !(m_valid && m_div_wait);
        bpv = m_valid && m_inst.register_write;
        w   = m_first ? data_read_data : m_word;
        check("io_allow_in", io_allow_in, !m_valid || (rg && wb_allow_in));
        check("wb_valid", io_to_wb_bus.valid, m_valid && rg);
        check("bp_valid", io_to_id_back_pass_bus.valid, bpv);
        check("bp_data_valid", io_to_id_back_pass_bus.data_valid, bpv && rg);
        check("bp_write_register", io_to_id_back_pass_bus.write_register,
              bpv ? m_inst.destination_register : 5'd0);
        if (m_valid) begin
            check("final_result", io_to_wb_bus.final_result, model_final(w));
            check("program_count", io_to_wb_bus.program_count, m_inst.program_count);
            check("wb_dest", io_to_wb_bus.destination_register, m_inst.destination_register);
            check("wb_register_write", io_to_wb_bus.register_write, m_inst.register_write);
            check("bp_write_data", io_to_id_back_pass_bus.write_data, model_final(w));
        end
    endtask

    // Advance the model by one clock using the inputs that were present at the edge.
    task automatic model_update();
        bit rg;
        bit allow;
        logic [63:0] p;
        if (reset) begin
            m_valid = 0; m_first = 0; m_div_wait = 0; m_hi = '0; m_lo = '0;
            return;
        end
        rg    = !(m_valid && m_div_wait);
        allow = !m_valid || (rg && wb_allow_in);
        p     = m_first ? ex_to_io_bus.multiply_result : m_prod;
        if (m_valid && rg && wb_allow_in) begin
            if (m_inst.is_multiply) begin
                m_hi = p[63:32]; m_lo = p[31:0];
            end else if (m_inst.is_divide) begin
                m_hi = m_rem; m_lo = m_quot;
            end else if (m_inst.high_low_write) begin
                if (m_inst.result_high) m_hi = m_inst.alu_result;
                if (m_inst.result_low)  m_lo = m_inst.alu_result;
            end
        end
        if (m_first) begin
            m_word = data_read_data;
            m_prod = ex_to_io_bus.multiply_result;
        end
        if (m_valid && m_div_wait && ex_to_io_bus.divide_result_valid) begin
            m_div_wait = 0;
            m_quot = ex_to_io_bus.divide_quotient;
            m_rem  = ex_to_io_bus.divide_remainder;
        end
        if (allow) begin
            m_valid    = ex_to_io_bus.valid;
            m_first    = ex_to_io_bus.valid;
            m_div_wait = ex_to_io_bus.valid && ex_to_io_bus.is_divide;
            if (ex_to_io_bus.valid) m_inst = ex_to_io_bus;
        end else begin
            m_first = 0;
        end
    endtask

    // Instruction kinds: 0 alu, 1 lb, 2 lh, 3 lw, 4 lwl, 5 lwr, 6 mult, 7 div,
    // 8 mfhi, 9 mflo, 10 mthi, 11 mtlo.
    function automatic EXToIOData mk_inst(input int kind);
        EXToIOData d;
        d = '0;
        d.valid                = 1'b1;
        d.program_count        = $urandom;
        d.destination_register = 5'($urandom);
        d.alu_result           = $urandom;
        d.memory_address_final = 2'($urandom);
        d.source_register_data = $urandom;
        d.memory_io_unsigned   = 1'($urandom);
        d.memory_io_size       = MEM_WORD;
        case (kind)
            0:  d.register_write = 1'($urandom);
            1:  begin d.register_write = 1; d.result_is_from_memory = 1; d.memory_io_size = MEM_BYTE; end
            2:  begin d.register_write = 1; d.result_is_from_memory = 1; d.memory_io_size = MEM_HALF; end
            3:  begin d.register_write = 1; d.result_is_from_memory = 1; end
            4:  begin d.register_write = 1; d.result_is_from_memory = 1; d.is_load_left = 1; end
            5:  begin d.register_write = 1; d.result_is_from_memory = 1; d.is_load_right = 1; end
            6:  d.is_multiply = 1;
            7:  d.is_divide = 1;
            8:  begin d.register_write = 1; d.result_high = 1; end
            9:  begin d.register_write = 1; d.result_low = 1; end
            10: begin d.high_low_write = 1; d.result_high = 1; end
            default: begin d.high_low_write = 1; d.result_low = 1; end
        endcase
        return d;
    endfunction

    task automatic set_in(input EXToIOData d, input logic wb, input logic [31:0] w,
                          input logic [63:0] p, input logic dv, input logic [31:0] q,
                          input logic [31:0] r);
        EXToIOData b;
        b = d;
        b.multiply_result     = p;
        b.divide_result_valid = dv;
        b.divide_quotient     = q;
        b.divide_remainder    = r;
        ex_to_io_bus   = b;
        wb_allow_in    = wb;
        data_read_data = w;
    endtask

    task automatic settle();
        @(negedge clock);
        compare_outputs();
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        model_update();
    endtask

    // One cycle with an otherwise empty bus.
    task automatic idle_cycle(input logic wb, input logic [31:0] w, input logic [63:0] p);
        set_in('0, wb, w, p, 1'b0, 32'd0, 32'd0);
        settle();
        tick();
    endtask

    task automatic issue(input EXToIOData d);
        set_in(d, 1'b1, $urandom, 64'd0, 1'b0, 32'd0, 32'd0);
        settle();
        tick();
    endtask

    // Issue a HI/LO move and check its result literally in its first stage cycle.
    task automatic read_hilo(input bit high, input logic [31:0] exp, input string name);
        issue(mk_inst(high ? 8 : 9));
        set_in('0, 1'b1, $urandom, 64'd0, 1'b0, 32'd0, 32'd0);
        settle();
        check(name, io_to_wb_bus.final_result, exp);
        tick();
    endtask

    initial begin
        EXToIOData d;
        reset = 1'b1;
        set_in('0, 1'b1, 32'd0, 64'd0, 1'b0, 32'd0, 32'd0);
        @(posedge clock);
        #1;
        model_update();
        armed = 1;
        idle_cycle(1'b1, 32'd0, 64'd0);
        reset = 1'b0;

        // Post-reset state.
        set_in('0, 1'b1, 32'd0, 64'd0, 1'b0, 32'd0, 32'd0);
        settle();
        check("reset_allow_in", io_allow_in, 1);
        check("reset_wb_valid", io_to_wb_bus.valid, 0);
        check("reset_bp_valid", io_to_id_back_pass_bus.valid, 0);
        tick();

        // Signed and unsigned byte loads.
        for (int u = 0; u < 2; u++) begin
            d = mk_inst(1);
            d.memory_address_final = 2'd2;
            d.memory_io_unsigned   = 1'(u);
            issue(d);
            set_in('0, 1'b1, 32'h1280_3456, 64'd0, 1'b0, 32'd0, 32'd0);
            settle();
            check(u == 0 ? "lb_sign_ext" : "lbu_zero_ext", io_to_wb_bus.final_result,
                  u == 0 ? 64'hFFFF_FF80 : 64'h0000_0080);
            tick();
        end

        // Partial-word left load.
        d = mk_inst(4);
        d.memory_address_final = 2'd1;
        d.source_register_data = 32'h1122_3344;
        issue(d);
        set_in('0, 1'b1, 32'hAABB_CCDD, 64'd0, 1'b0, 32'd0, 32'd0);
        settle();
`ifdef IO_UNALIGNED_LOAD_EN
        check("lwl_merge", io_to_wb_bus.final_result, 64'hCCDD_3344);
`else
        check("lwl_as_word", io_to_wb_bus.final_result, 64'hAABB_CCDD);
`endif
        tick();

        // Multiply then read HI and LO.
        issue(mk_inst(6));
        idle_cycle(1'b1, 32'd0, 64'h0000_0002_0000_0001);
        read_hilo(1, 32'd2, "mult_mfhi");
        read_hilo(0, 32'd1, "mult_mflo");

        // Divide stall: result valid arrives in the fifth stage cycle.
        issue(mk_inst(7));
        for (int k = 1; k <= 5; k++) begin
            set_in('0, 1'b1, 32'd0, 64'd0, k == 5, k == 5 ? 32'd7 : 32'd0, k == 5 ? 32'd3 : 32'd0);
            settle();
            check("div_stall_allow_in", io_allow_in, 0);
            check("div_stall_wb_valid", io_to_wb_bus.valid, 0);
            tick();
        end
        set_in('0, 1'b1, 32'd0, 64'd0, 1'b0, 32'd0, 32'd0);
        settle();
        check("div_done_allow_in", io_allow_in, 1);
        check("div_done_wb_valid", io_to_wb_bus.valid, 1);
        tick();
        read_hilo(0, 32'd7, "div_mflo");
        read_hilo(1, 32'd3, "div_mfhi");

        // WB stall with a load in the stage while the SRAM word keeps changing.
        d = mk_inst(3);
        issue(d);
        for (int k = 0; k < 4; k++) begin
            set_in('0, k == 3, k == 0 ? 32'hDEAD_BEEF : $urandom, 64'd0, 1'b0, 32'd0, 32'd0);
            settle();
            check("lw_stall_hold", io_to_wb_bus.final_result, 64'hDEAD_BEEF);
            tick();
        end

        // WB stall with a multiply in the stage while the multiplier output changes.
        issue(mk_inst(6));
        for (int k = 0; k < 4; k++) begin
            set_in('0, k == 3, $urandom,
                   k == 0 ? 64'h0000_0005_0000_0009 : {$urandom, $urandom},
                   1'b0, 32'd0, 32'd0);
            settle();
            tick();
        end
        read_hilo(1, 32'd5, "mult_stall_mfhi");
        read_hilo(0, 32'd9, "mult_stall_mflo");

        // Reset while a divide is waiting.
        issue(mk_inst(7));
        idle_cycle(1'b1, 32'd0, 64'd0);
        idle_cycle(1'b1, 32'd0, 64'd0);
        reset = 1'b1;
        idle_cycle(1'b1, 32'd0, 64'd0);
        reset = 1'b0;
        set_in('0, 1'b1, 32'd0, 64'd0, 1'b0, 32'd0, 32'd0);
        settle();
        check("rst_div_allow_in", io_allow_in, 1);
        check("rst_div_wb_valid", io_to_wb_bus.valid, 0);
        tick();
        read_hilo(1, 32'd0, "rst_div_mfhi");
        read_hilo(0, 32'd0, "rst_div_mflo");

        // Randomized traffic with WB back-pressure and divider latency.
        for (int i = 0; i < 3000; i++) begin
            d = ($urandom_range(2) != 0) ? mk_inst(int'($urandom_range(11))) : '0;
            reset = ($urandom_range(499) == 0);
            set_in(d, $urandom_range(3) != 0, $urandom, {$urandom, $urandom},
                   $urandom_range(3) == 0, $urandom, $urandom);
            settle();
            tick();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
